// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register-file write port, with a busy-register
// scoreboard that lets decode stall on RAW hazards against in-flight writes.
module rf_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_rd,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_rd,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             flush,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             hazard,
  output logic             rf_RW,
  output logic [4:0]       rf_write,
  output logic [31:0]      rf_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic        rr_last;
  logic        grant0;
  logic        grant1;
  logic [31:0] busy;
  logic [31:0] busy_next;

  // rr_last names the most recent winner; on a conflict the other side goes next.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || rr_last);
    grant1 = req1_valid && (!req0_valid || !rr_last);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= 1'b1;
      rf_RW    <= 1'b0;
      rf_write <= 5'd0;
      rf_data  <= 32'd0;
    end else if (grant0) begin
      rr_last  <= 1'b0;
      rf_RW    <= 1'b1;
      rf_write <= req0_rd;
      rf_data  <= req0_data;
    end else if (grant1) begin
      rr_last  <= 1'b1;
      rf_RW    <= 1'b1;
      rf_write <= req1_rd;
      rf_data  <= req1_data;
    end else begin
      rf_RW    <= 1'b0;
    end
  end

  // Clear is applied before set so a newly issued producer of the same rd stays busy.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = 32'd0;
    end
    if (rf_RW) begin
      busy_next[rf_write] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    hazard = ((rs1 != 5'd0) && busy[rs1]) || ((rs2 != 5'd0) && busy[rs2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset/saturation sequences,
// then randomized traffic against a transaction-level reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1, rs2;
  logic        hazard;
  logic        rf_RW;
  logic [4:0]  rf_write;
  logic [31:0] rf_data;
  logic [15:0] conflict_cnt;

  logic        s_req0_ready, s_req1_ready, s_hazard, s_rf_RW;
  logic [4:0]  s_rf_write;
  logic [31:0] s_rf_data;
  logic [2:0]  s_conflict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rf_RW(rf_RW), .rf_write(rf_write), .rf_data(rf_data), .conflict_cnt(conflict_cnt)
  );

  rf_wb_arbiter #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .hazard(s_hazard),
    .rf_RW(s_rf_RW), .rf_write(s_rf_write), .rf_data(s_rf_data), .conflict_cnt(s_conflict_cnt)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        r0;
    logic        r1;
    logic        haz;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [15:0] cnt;
  } vec_t;

  vec_t rows[$];

  // Reference model: one transaction per cycle, busy set kept as a plain array.
  bit          m_rw;
  bit [4:0]    m_wr;
  bit [31:0]   m_wd;
  bit          m_busy[32];
  longint      m_conf;
  int          m_last;

  function automatic int modelWinner();
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit modelHazard();
    return (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    req0_valid  = v.v0;
    req0_rd     = v.rd0;
    req0_data   = v.d0;
    req1_valid  = v.v1;
    req1_rd     = v.rd1;
    req1_data   = v.d1;
    issue_valid = v.iv;
    issue_rd    = v.ird;
    flush       = v.fl;
    rs1         = v.rs1;
    rs2         = v.rs2;
  endtask

  task automatic driveIdle();
    rst = 0; req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    issue_valid = 0; issue_rd = 0; flush = 0; rs1 = 0; rs2 = 0;
  endtask

  // Update the model from the inputs presented this cycle, then cross the edge.
  task automatic advance();
    int        w;
    bit        old_rw;
    bit [4:0]  old_wr;
    w = modelWinner();
    old_rw = m_rw;
    old_wr = m_wr;
    if (rst) begin
      m_rw = 0; m_wr = 0; m_wd = 0; m_conf = 0; m_last = 1;
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (w == 0) begin
        m_rw = 1; m_wr = req0_rd; m_wd = req0_data; m_last = 0;
      end else if (w == 1) begin
        m_rw = 1; m_wr = req1_rd; m_wd = req1_data; m_last = 1;
      end else begin
        m_rw = 0;
      end
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
      if (old_rw) m_busy[old_wr] = 0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      if (req0_valid && req1_valid) m_conf++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input int cyc);
    logic [31:0] e_cnt, e_small;
    int          w;
    w = modelWinner();
    e_cnt   = (m_conf > 65535) ? 32'd65535 : 32'(m_conf);
    e_small = (m_conf > 7) ? 32'd7 : 32'(m_conf);
    checkOutput($sformatf("rnd%0d req0_ready", cyc), {31'd0, req0_ready}, {31'd0, w == 0});
    checkOutput($sformatf("rnd%0d req1_ready", cyc), {31'd0, req1_ready}, {31'd0, w == 1});
    checkOutput($sformatf("rnd%0d hazard", cyc), {31'd0, hazard}, {31'd0, modelHazard()});
    checkOutput($sformatf("rnd%0d rf_RW", cyc), {31'd0, rf_RW}, {31'd0, m_rw});
    checkOutput($sformatf("rnd%0d rf_write", cyc), {27'd0, rf_write}, {27'd0, m_wr});
    checkOutput($sformatf("rnd%0d rf_data", cyc), rf_data, m_wd);
    checkOutput($sformatf("rnd%0d conflict_cnt", cyc), {16'd0, conflict_cnt}, e_cnt);
    checkOutput($sformatf("rnd%0d small_cnt", cyc), {29'd0, s_conflict_cnt}, e_small);
  endtask

  task automatic addRow(
    input logic r, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
    input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
    input logic iv, input logic [4:0] ird, input logic fl,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic r0, input logic r1, input logic haz, input logic rw,
    input logic [4:0] wr, input logic [31:0] wd, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.iv = iv; v.ird = ird; v.fl = fl; v.rs1 = a1; v.rs2 = a2;
    v.r0 = r0; v.r1 = r1; v.haz = haz; v.rw = rw; v.wr = wr; v.wd = wd; v.cnt = cnt;
    rows.push_back(v);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] DA = 32'h1111_0001;
  localparam logic [31:0] DBB = 32'h2222_0002;
  localparam logic [31:0] D7 = 32'h0000_0077;
  localparam logic [31:0] D3 = 32'h0000_0033;

  initial begin
    bit g0, g1;

    m_rw = 0; m_wr = 0; m_wd = 0; m_conf = 0; m_last = 1;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;

    // single write, then idle
    addRow(0,1,5,DB, 0,0,0,  0,0,0, 0,0,  1,0,0,0,0,0,0);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0,1,5,DB,0);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0,0,5,DB,0);
    addRow(1,0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0,0,5,DB,0);
    // four-cycle conflict, alternating grants
    addRow(0,1,1,DA, 1,2,DBB, 0,0,0, 0,0, 1,0,0,0,0,0,0);
    addRow(0,1,1,DA, 1,2,DBB, 0,0,0, 0,0, 0,1,0,1,1,DA,1);
    addRow(0,1,1,DA, 1,2,DBB, 0,0,0, 0,0, 1,0,0,1,2,DBB,2);
    addRow(0,1,1,DA, 1,2,DBB, 0,0,0, 0,0, 0,1,0,1,1,DA,3);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 0,0,  0,0,0,1,2,DBB,4);
    // issue x7, write it back, hazard clears after commit
    addRow(0,0,0,0,  0,0,0,  1,7,0, 7,0,  0,0,0,0,2,DBB,4);
    addRow(0,1,7,D7, 0,0,0,  0,0,0, 7,0,  1,0,1,0,2,DBB,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 7,0,  0,0,1,1,7,D7,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 7,0,  0,0,0,0,7,D7,4);
    // x0 never hazards; x5 busy seen through either source port
    addRow(0,0,0,0,  0,0,0,  1,5,0, 0,0,  0,0,0,0,7,D7,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 0,5,  0,0,1,0,7,D7,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 5,0,  0,0,1,0,7,D7,4);
    // same-rd clear and set in one cycle
    addRow(0,0,0,0,  0,0,0,  1,3,0, 0,0,  0,0,0,0,7,D7,4);
    addRow(0,1,3,D3, 0,0,0,  0,0,0, 3,0,  1,0,1,0,7,D7,4);
    addRow(0,0,0,0,  0,0,0,  1,3,0, 3,0,  0,0,1,1,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 3,0,  0,0,1,0,3,D3,4);
    // flush with simultaneous issue
    addRow(0,0,0,0,  0,0,0,  1,4,0, 0,0,  0,0,0,0,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  1,9,0, 0,0,  0,0,0,0,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  1,12,1, 4,9, 0,0,1,0,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 4,9,  0,0,0,0,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 12,0, 0,0,1,0,3,D3,4);
    addRow(0,0,0,0,  0,0,0,  0,0,0, 3,5,  0,0,0,0,3,D3,4);

    driveIdle();
    rst = 1;
    advance();
    advance();

    $display("[TB] directed vector table");
    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(rows[i]);
      #1;
      checkOutput($sformatf("row%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, rows[i].r0});
      checkOutput($sformatf("row%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, rows[i].r1});
      checkOutput($sformatf("row%0d hazard", i), {31'd0, hazard}, {31'd0, rows[i].haz});
      checkOutput($sformatf("row%0d rf_RW", i), {31'd0, rf_RW}, {31'd0, rows[i].rw});
      checkOutput($sformatf("row%0d rf_write", i), {27'd0, rf_write}, {27'd0, rows[i].wr});
      checkOutput($sformatf("row%0d rf_data", i), rf_data, rows[i].wd);
      checkOutput($sformatf("row%0d conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, rows[i].cnt});
      checkOutput($sformatf("row%0d small_cnt", i), {29'd0, s_conflict_cnt}, {16'd0, rows[i].cnt});
      advance();
    end

    $display("[TB] saturation and mid-operation reset");
    driveIdle();
    rst = 1;
    #1;
    advance();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req0_rd = 5'd1; req0_data = 32'(i);
      req1_valid = 1; req1_rd = 5'd2; req1_data = 32'(100 + i);
      issue_valid = 1; issue_rd = 5'(10 + i);
      #1;
      advance();
    end
    driveIdle();
    rst = 1; rs1 = 5'd10; rs2 = 5'd11;
    #1;
    checkOutput("sat rf_RW before reset", {31'd0, rf_RW}, 32'd1);
    checkOutput("sat conflict_cnt", {16'd0, conflict_cnt}, 32'd10);
    checkOutput("sat small_cnt", {29'd0, s_conflict_cnt}, 32'd7);
    checkOutput("sat hazard before reset", {31'd0, hazard}, 32'd1);
    advance();
    rst = 0;
    #1;
    checkOutput("rst rf_RW", {31'd0, rf_RW}, 32'd0);
    checkOutput("rst rf_write", {27'd0, rf_write}, 32'd0);
    checkOutput("rst rf_data", rf_data, 32'd0);
    checkOutput("rst conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    checkOutput("rst small_cnt", {29'd0, s_conflict_cnt}, 32'd0);
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(32 - r);
      #1;
      checkOutput($sformatf("rst busy x%0d", r), {31'd0, hazard}, 32'd0);
    end
    driveIdle();
    #1;
    advance();

    $display("[TB] randomized traffic against model");
    g0 = 0; g1 = 0;
    for (int c = 0; c < 800; c++) begin
      if (!(req0_valid && !g0)) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_rd    = 5'($urandom);
        req0_data  = $urandom;
      end
      if (!(req1_valid && !g1)) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_rd    = 5'($urandom);
        req1_data  = $urandom;
      end
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 29) == 0);
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_rd    = 5'($urandom);
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      #1;
      checkModel(c);
      g0 = (modelWinner() == 0);
      g1 = (modelWinner() == 1);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
